// File: rtl/csa_arbiter.sv
// ============================================================================
// Module   : csa_arbiter (with carry_saveadder)
// Brief    : Two-requester round-robin front end sharing one 4-operand
//            carry-save adder. Optional macro CSA_ACC_EN adds per-requester
//            8-bit accumulators.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module carry_saveadder (
    input  logic [2:0] i_a,
    input  logic [2:0] i_b,
    input  logic [2:0] i_c,
    input  logic [2:0] i_d,
    output logic [3:0] o_sum_total,
    output logic       o_final_carryout
);
    logic [2:0] w_s1;
    logic [2:0] w_c1;
    logic [3:0] w_x;
    logic [3:0] w_y;
    logic [3:0] w_z;
    logic [3:0] w_s2;
    logic [3:0] w_c2;

    // Two carry-save compression levels, then one carry-propagate add
    assign w_s1 = i_a ^ i_b ^ i_c;
    assign w_c1 = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

    assign w_x  = {1'b0, w_s1};
    assign w_y  = {w_c1, 1'b0};
    assign w_z  = {1'b0, i_d};
    assign w_s2 = w_x ^ w_y ^ w_z;
    assign w_c2 = (w_x & w_y) | (w_x & w_z) | (w_y & w_z);

    assign {o_final_carryout, o_sum_total} = {1'b0, w_s2} + {w_c2, 1'b0};
endmodule

module csa_arbiter #(
    parameter int PRIO_INIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [11:0] req0_ops,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [11:0] req1_ops,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_data,
    output logic        busy,
    input  logic [1:0]  acc_clr
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_ptr;
    logic        r_id;
    logic [11:0] r_ops;
    logic [7:0]  r_rsp_data;
    logic        w_grant0;
    logic        w_grant1;
    logic [3:0]  w_sum_total;
    logic        w_cout;
    logic [4:0]  w_result;
    logic [7:0]  w_rsp_next;

    carry_saveadder u_csa (
        .i_a              (r_ops[2:0]),
        .i_b              (r_ops[5:3]),
        .i_c              (r_ops[8:6]),
        .i_d              (r_ops[11:9]),
        .o_sum_total      (w_sum_total),
        .o_final_carryout (w_cout)
    );

    assign w_result = {w_cout, w_sum_total};

    // Pointer only matters when both requesters contend
    assign w_grant0 = req0_valid & (~req1_valid | ~r_ptr);
    assign w_grant1 = req1_valid & (~req0_valid |  r_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ready = rst_n & w_grant0;
                req1_ready = rst_n & w_grant1;
                if (req0_ready || req1_ready) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef CSA_ACC_EN
    logic [7:0] r_acc [0:1];
    logic [7:0] w_acc_base;

    // A clear coinciding with the update means the result starts from zero
    assign w_acc_base = acc_clr[r_id] ? 8'd0 : r_acc[r_id];
    assign w_rsp_next = w_acc_base + {3'b000, w_result};

    for (genvar gi = 0; gi < 2; gi++) begin : g_acc
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc[gi] <= 8'd0;
            end else if ((r_state == S_CALC) && (r_id == gi[0])) begin
                r_acc[gi] <= w_rsp_next;
            end else if (acc_clr[gi]) begin
                r_acc[gi] <= 8'd0;
            end
        end
    end
`else
    logic w_unused_acc_clr;

    assign w_unused_acc_clr = ^acc_clr;
    assign w_rsp_next       = {3'b000, w_result};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= 1'(PRIO_INIT);
            r_id       <= 1'b0;
            r_ops      <= 12'd0;
            r_rsp_data <= 8'd0;
        end else begin
            if (req0_ready || req1_ready) begin
                r_ops <= req1_ready ? req1_ops : req0_ops;
                r_id  <= req1_ready;
                r_ptr <= ~req1_ready;
            end
            if (r_state == S_CALC) begin
                r_rsp_data <= w_rsp_next;
            end
        end
    end

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != S_IDLE);
endmodule

`default_nettype wire

// File: tb/tb_csa_arbiter.sv
// ============================================================================
// Module   : tb_csa_arbiter
// Brief    : Directed self-checking bench for csa_arbiter (CSA_ACC_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csa_arbiter;
    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic        req0_ready;
    logic [11:0] req0_ops;
    logic        req1_valid;
    logic        req1_ready;
    logic [11:0] req1_ops;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [7:0]  rsp_data;
    logic        busy;
    logic [1:0]  acc_clr;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] m_acc [0:1];

    localparam logic [11:0] C_OPS_ALL7 = 12'hFFF;  // 7+7+7+7 = 28
    localparam logic [11:0] C_OPS_1230 = 12'h0D1;  // a=1 b=2 c=3 d=0 -> 6
    localparam logic [11:0] C_OPS_5674 = 12'h9F5;  // a=5 b=6 c=7 d=4 -> 22

    csa_arbiter #(.PRIO_INIT(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ops   (req0_ops),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ops   (req1_ops),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .acc_clr    (acc_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected response for a new result: plain sum, or running total per id
    function automatic logic [7:0] exp_rsp(input logic id, input logic [7:0] sum);
`ifdef CSA_ACC_EN
        m_acc[id] = m_acc[id] + sum;
        return m_acc[id];
`else
        return sum;
`endif
    endfunction

`ifdef CSA_ACC_EN
    task automatic do_op(input logic id, input logic [11:0] ops,
                         input logic [1:0] clr, input logic [7:0] exp);
        if (id) begin
            req1_valid = 1'b1;
            req1_ops   = ops;
        end else begin
            req0_valid = 1'b1;
            req0_ops   = ops;
        end
        #1;
        chk("acc_ready", id ? req1_ready : req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        acc_clr    = clr;
        tick();
        acc_clr = 2'b00;
        chk("acc_rsp_valid", rsp_valid, 1);
        chk("acc_rsp_id", rsp_id, id);
        chk("acc_rsp_data", rsp_data, exp);
        tick();
    endtask
`endif

    initial begin
        logic [7:0] e;
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_ops   = 12'd0;
        req1_ops   = 12'd0;
        rsp_ready  = 1'b1;
        acc_clr    = 2'b00;
        m_acc[0]   = 8'd0;
        m_acc[1]   = 8'd0;
        repeat (2) tick();

        // Reset state and single all-sevens operation
        req0_valid = 1'b1;
        req0_ops   = C_OPS_ALL7;
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        rst_n = 1'b1;
        #1;
        chk("s1_ready0", req0_ready, 1);
        chk("s1_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        chk("s1_calc_busy", busy, 1);
        chk("s1_calc_valid", rsp_valid, 0);
        chk("s1_calc_ready0", req0_ready, 0);
        tick();
        e = exp_rsp(1'b0, 8'd28);
        chk("s1_rsp_valid", rsp_valid, 1);
        chk("s1_rsp_data", rsp_data, e);
        chk("s1_rsp_id", rsp_id, 0);
        tick();
        chk("s1_one_cycle", rsp_valid, 0);
        chk("s1_idle_busy", busy, 0);

        // Fresh reset, then both requesters contend continuously
        rst_n = 1'b0;
        #1;
        rst_n    = 1'b1;
        m_acc[0] = 8'd0;
        m_acc[1] = 8'd0;
        req0_ops   = C_OPS_1230;
        req1_ops   = C_OPS_1230;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic w;
            w = 1'(i % 2);
            #1;
            chk("rr_ready0", req0_ready, !w);
            chk("rr_ready1", req1_ready, w);
            tick();
            tick();
            e = exp_rsp(w, 8'd6);
            chk("rr_rsp_valid", rsp_valid, 1);
            chk("rr_rsp_id", rsp_id, w);
            chk("rr_rsp_data", rsp_data, e);
            tick();
        end
        req1_valid = 1'b0;

        // Consumer stalls in RESP for five cycles
        req0_ops  = C_OPS_5674;
        rsp_ready = 1'b0;
        tick();
        tick();
        e = exp_rsp(1'b0, 8'd22);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, e);
            chk("stall_id", rsp_id, 0);
            chk("stall_ready0", req0_ready, 0);
            chk("stall_ready1", req1_ready, 0);
            chk("stall_busy", busy, 1);
            tick();
        end
        req0_valid = 1'b0;
        rsp_ready  = 1'b1;
        tick();
        chk("stall_release_valid", rsp_valid, 0);
        chk("stall_release_busy", busy, 0);

        // Reset while CALC discards the operation and restores the pointer
        req0_valid = 1'b1;
        req0_ops   = C_OPS_ALL7;
        tick();
        req0_valid = 1'b0;
        chk("rc_calc_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rc_rsp_valid", rsp_valid, 0);
        chk("rc_busy", busy, 0);
        chk("rc_rsp_data", rsp_data, 0);
        m_acc[0] = 8'd0;
        m_acc[1] = 8'd0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rc_no_rsp", rsp_valid, 0);
            chk("rc_idle", busy, 0);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rc_ptr_ready0", req0_ready, 1);
        chk("rc_ptr_ready1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

`ifdef CSA_ACC_EN
        // Accumulator wrap, clear-with-update, and per-requester isolation
        for (int i = 1; i <= 10; i++) begin
            logic [7:0] k;
            k = 8'(28 * i);
            do_op(1'b0, C_OPS_ALL7, 2'b00, k);
        end
        do_op(1'b0, C_OPS_ALL7, 2'b01, 8'd28);
        do_op(1'b1, C_OPS_1230, 2'b00, 8'd6);
        do_op(1'b0, C_OPS_ALL7, 2'b00, 8'd56);
        do_op(1'b1, C_OPS_1230, 2'b00, 8'd12);
        acc_clr = 2'b10;
        tick();
        acc_clr = 2'b00;
        do_op(1'b0, C_OPS_ALL7, 2'b00, 8'd84);
        do_op(1'b1, C_OPS_1230, 2'b00, 8'd6);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
